uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 73 +++++++
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : state encodings and baud divisor shared by uart_rx and uart_tx
// Rev 1.0
// ============================================================================
package uart_pkg;

    localparam int c_BAUD_CNT_W = 16;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    function automatic int calc_baud_ticks(input int clock_freq, input int baudrate);
        return clock_freq / baudrate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : first-word-fall-through FIFO; push ignored when full
// Rev 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                 c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]      c_FULL = (c_AW + 1)'(DEPTH);

    generate
        if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_tx_fifo: DEPTH must be a power of two in 2..256");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from registered count only, so a slot freed this edge
    // cannot be refilled until the next one.
    assign full    = (r_count == c_FULL);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : FIFO-buffered 8N1 UART transmitter with registered serial output
// Rev 1.0
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUDRATE   = 115200,
    parameter int CLOCK_FREQ = 27000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                      c_BAUD_TICKS = calc_baud_ticks(CLOCK_FREQ, BAUDRATE);
    localparam logic [c_BAUD_CNT_W-1:0] c_BAUD_LAST  = c_BAUD_CNT_W'(c_BAUD_TICKS - 1);

    generate
        if ((c_BAUD_TICKS < 2) || (c_BAUD_TICKS > 65535)) begin : g_baud_check
            $error("uart_tx: BAUD_TICKS must lie in 2..65535");
        end
    endgenerate

    logic [1:0]              r_state;
    logic [c_BAUD_CNT_W-1:0] r_baud_cnt;
    logic [2:0]              r_bit_idx;
    logic [7:0]              r_shift;
    logic                    r_tx;

    logic [7:0]              w_fifo_data;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_bit_end;
    logic                    w_pop;
    logic                    w_tx_next;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (w_pop),
        .rd_data (w_fifo_data),
        .count   (fifo_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);
    // The stop bit hands straight over to the next queued byte, so frames
    // can run back to back without an idle cycle.
    assign w_pop     = ~w_empty & ((r_state == c_ST_IDLE) |
                                   ((r_state == c_ST_STOP) & w_bit_end));
    assign tx_ready  = ~w_full;
    assign tx_busy   = ~((r_state == c_ST_IDLE) & w_empty);
    assign tx        = r_tx;

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            c_ST_START: w_tx_next = 1'b0;
            c_ST_DATA:  w_tx_next = r_shift[0];
            default:    w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_shift    <= w_fifo_data;
                        r_baud_cnt <= '0;
                        r_state    <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= c_ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (!w_empty) begin
                            r_shift <= w_fifo_data;
                            r_state <= c_ST_START;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : directed self-checking bench for uart_tx (10 clocks per bit)
// Rev 1.0
// ============================================================================
module tb_uart_tx;

    localparam int c_BT = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_bytes [$];
    int         rx_fall  [$];
    logic       rx_stop  [$];
    logic [7:0] rx_shift;
    int         rx_edge;

    uart_tx #(
        .BAUDRATE   (100000),
        .CLOCK_FREQ (1000000),
        .FIFO_DEPTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference receiver: samples each bit in the middle of its period.
    initial begin : rx_model
        forever begin
            @(posedge clock); #1;
            if (!reset && tx === 1'b0) begin
                rx_edge = cyc;
                repeat (c_BT + c_BT / 2) begin @(posedge clock); #1; end
                rx_shift[0] = tx;
                for (int k = 1; k < 8; k++) begin
                    repeat (c_BT) begin @(posedge clock); #1; end
                    rx_shift[k] = tx;
                end
                repeat (c_BT) begin @(posedge clock); #1; end
                rx_bytes.push_back(rx_shift);
                rx_fall.push_back(rx_edge);
                rx_stop.push_back(tx);
            end
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clock);
        $display("FAIL watchdog: simulation exceeded 80000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic push(input logic [7:0] d, output int n);
        tx_data  = d;
        tx_valid = 1'b1;
        step(1);
        n        = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic clear_rx();
        rx_bytes.delete();
        rx_fall.delete();
        rx_stop.delete();
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        int t = 0;
        while (rx_bytes.size() < n && t < budget) begin
            step(1);
            t++;
        end
        checks++;
        if (rx_bytes.size() < n) begin
            errors++;
            $display("FAIL %s: timeout, got %0d bytes, expected %0d", name, rx_bytes.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        reset = 1'b0;
        step(2);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx: got %b expected 1", tx); end
        clear_rx();
    endtask

    task automatic test_single();
        int n;
        int lows;
        logic [7:0] exp;
        exp = 8'hA5;
        push(8'hA5, n);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_n: got %0d expected 1", fifo_count); end
        step(1);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_n1: got %b expected 1", tx); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_n1: got %0d expected 0", fifo_count); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", tx_busy); end
        step(1);
        lows = (tx === 1'b0) ? 1 : 0;
        for (int i = 0; i < c_BT - 1; i++) begin
            step(1);
            if (tx === 1'b0) lows++;
        end
        checks++; if (lows !== c_BT) begin errors++; $display("FAIL single_start: got %0d low cycles expected %0d", lows, c_BT); end
        step(6);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (tx !== exp[k]) begin errors++; $display("FAIL single_bit%0d: got %b expected %b", k, tx, exp[k]); end
            step(c_BT);
        end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_stop: got %b expected 1", tx); end
        step(3);
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_n100: got %b expected 1", tx_busy); end
        step(2);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_n102: got %b expected 0", tx_busy); end
        wait_rx(1, 200, "single_rx");
        if (rx_bytes.size() >= 1) begin
            checks++; if (rx_bytes[0] !== 8'hA5) begin errors++; $display("FAIL single_rx_byte: got %h expected a5", rx_bytes[0]); end
            checks++; if (rx_fall[0] !== n + 2) begin errors++; $display("FAIL single_latency: got fall at %0d expected %0d", rx_fall[0], n + 2); end
        end
        step(10);
        clear_rx();
    endtask

    task automatic test_back_to_back();
        int n;
        int m;
        push(8'h00, n);
        push(8'hFF, m);
        wait_rx(2, 400, "b2b_rx");
        if (rx_bytes.size() >= 2) begin
            checks++; if (rx_bytes[0] !== 8'h00) begin errors++; $display("FAIL b2b_byte0: got %h expected 00", rx_bytes[0]); end
            checks++; if (rx_bytes[1] !== 8'hFF) begin errors++; $display("FAIL b2b_byte1: got %h expected ff", rx_bytes[1]); end
            checks++; if (rx_fall[0] !== n + 2) begin errors++; $display("FAIL b2b_first_fall: got %0d expected %0d", rx_fall[0], n + 2); end
            checks++; if (rx_fall[1] - rx_fall[0] !== 10 * c_BT) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", rx_fall[1] - rx_fall[0], 10 * c_BT); end
            checks++; if (rx_stop[1] !== 1'b1) begin errors++; $display("FAIL b2b_stop: got %b expected 1", rx_stop[1]); end
        end
        step(10);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", tx_busy); end
        clear_rx();
    endtask

    task automatic test_full();
        int accepted = 0;
        int t = 0;
        int seen = 0;
        int acc_at_full = -1;
        int rx_at_full = -1;
        logic [2:0] cnt_at_full = 3'd0;
        tx_valid = 1'b1;
        while (accepted < 6 && t < 3000) begin
            tx_data = 8'(accepted + 1);
            if (tx_ready === 1'b1) begin
                step(1);
                accepted++;
            end else begin
                if (seen == 0) begin
                    seen = 1;
                    acc_at_full = accepted;
                    cnt_at_full = fifo_count;
                    rx_at_full = rx_bytes.size();
                end
                step(1);
            end
            t++;
        end
        tx_valid = 1'b0;
        checks++; if (accepted !== 6) begin errors++; $display("FAIL full_accepted: got %0d expected 6", accepted); end
        checks++; if (acc_at_full !== 5) begin errors++; $display("FAIL full_drop_point: got %0d accepted expected 5", acc_at_full); end
        checks++; if (cnt_at_full !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", cnt_at_full); end
        checks++; if (rx_at_full !== 0) begin errors++; $display("FAIL full_in_flight: got %0d received expected 0", rx_at_full); end
        wait_rx(6, 1000, "full_rx");
        checks++; if (rx_bytes.size() !== 6) begin errors++; $display("FAIL full_rx_count: got %0d expected 6", rx_bytes.size()); end
        for (int i = 0; i < 6 && i < rx_bytes.size(); i++) begin
            checks++;
            if (rx_bytes[i] !== 8'(i + 1)) begin errors++; $display("FAIL full_order%0d: got %h expected %h", i, rx_bytes[i], 8'(i + 1)); end
        end
        step(10);
        clear_rx();
    endtask

    task automatic test_reset_mid();
        int n;
        int m;
        int lows = 0;
        push(8'h3C, n);
        push(8'h11, m);
        push(8'h22, m);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rmid_queued: got %0d expected 2", fifo_count); end
        step(44);
        reset = 1'b1;
        step(1);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmid_tx: got %b expected 1", tx); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", fifo_count); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", tx_busy); end
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (tx !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL rmid_silent: got %0d non-idle cycles expected 0", lows); end
        clear_rx();
        push(8'h81, n);
        wait_rx(1, 200, "rmid_rx");
        if (rx_bytes.size() >= 1) begin
            checks++; if (rx_bytes[0] !== 8'h81) begin errors++; $display("FAIL rmid_after: got %h expected 81", rx_bytes[0]); end
            checks++; if (rx_stop[0] !== 1'b1) begin errors++; $display("FAIL rmid_after_stop: got %b expected 1", rx_stop[0]); end
        end
        step(10);
        clear_rx();
    endtask

    task automatic test_loopback();
        int accepted = 0;
        int t = 0;
        tx_valid = 1'b1;
        while (accepted < 256 && t < 30000) begin
            tx_data = 8'(accepted);
            if (tx_ready === 1'b1) begin
                step(1);
                accepted++;
            end else begin
                step(1);
            end
            t++;
        end
        tx_valid = 1'b0;
        checks++; if (accepted !== 256) begin errors++; $display("FAIL loop_accepted: got %0d expected 256", accepted); end
        wait_rx(256, 1000, "loop_rx");
        for (int i = 0; i < 256 && i < rx_bytes.size(); i++) begin
            checks++;
            if (rx_bytes[i] !== 8'(i) || rx_stop[i] !== 1'b1) begin
                errors++;
                $display("FAIL loop_byte%0d: got %h stop %b expected %h stop 1", i, rx_bytes[i], rx_stop[i], 8'(i));
            end
        end
        clear_rx();
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
